// File: rtl/pwm_meter.sv
// PWM period / high-time meter: synchronizes and deglitches an asynchronous
// square wave, then measures cycles between accepted edges with a timeout.
module pwm_meter #(
  parameter int          CNT_W   = 24,
  parameter int          GLITCH  = 4,
  parameter int unsigned TIMEOUT = (1 << CNT_W) - 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pwm_data,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_locked
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
  localparam logic [3:0]       STAB_LAST = 4'(GLITCH - 1);

  logic [1:0] sync_q;
  logic       filt_q;
  logic       filt_d_q;
  logic [3:0] stab_q;
  logic       rise_q;
  logic       fall_q;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [CNT_W-1:0] high_lat_q, high_lat_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, timeout_n;

  // Input conditioning: the filter only flips after GLITCH consecutive
  // synchronized samples disagree with it; any agreeing sample restarts the run.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the synchronizer chain actually shift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q   <= '0;
      filt_q   <= 1'b0;
      filt_d_q <= 1'b0;
      stab_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], i_pwm_data};
      filt_d_q <= filt_q;
      rise_q   <= filt_q & ~filt_d_q;
      fall_q   <= ~filt_q & filt_d_q;
      if (sync_q[1] != filt_q) begin
        if (stab_q == STAB_LAST) begin
          filt_q <= ~filt_q;
          stab_q <= '0;
        end else begin
          stab_q <= stab_q + 4'd1;
        end
      end else begin
        stab_q <= '0;
      end
    end
  end

  // Saturating increment: TIMEOUT bounds the counter so it can never wrap.
  assign cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every output of this block gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    high_lat_n = high_lat_q;
    period_n   = o_period;
    high_n     = o_high;
    valid_n    = 1'b0;
    timeout_n  = 1'b0;

    if (!i_en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_q) begin
            state_n = MEAS_HIGH;
            cnt_n   = CNT_W'(1);
          end
        end
        MEAS_HIGH: begin
          if (fall_q) begin
            state_n    = MEAS_LOW;
            high_lat_n = cnt_q;
            cnt_n      = cnt_inc;
          end else if (cnt_q == TMO) begin
            state_n   = IDLE;
            cnt_n     = '0;
            timeout_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        MEAS_LOW: begin
          if (rise_q) begin
            state_n  = MEAS_HIGH;
            period_n = cnt_q;
            high_n   = high_lat_q;
            valid_n  = 1'b1;
            cnt_n    = CNT_W'(1);
          end else if (cnt_q == TMO) begin
            state_n   = IDLE;
            cnt_n     = '0;
            timeout_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_lat_q <= '0;
      o_period   <= '0;
      o_high     <= '0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      high_lat_q <= high_lat_n;
      o_period   <= period_n;
      o_high     <= high_n;
      o_valid    <= valid_n;
      o_timeout  <= timeout_n;
    end
  end

  assign o_locked = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter: stimulus queues expected measurements,
// a negedge monitor pops and compares them whenever o_valid is seen.
module tb_pwm_meter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm;
  logic             en;
  logic [CNT_W-1:0] o_period, o_high;
  logic             o_valid, o_timeout, o_locked;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } exp_t;

  exp_t    exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc      = 0;
  int      to_cnt   = 0;
  int      to_cyc   = 0;
  int      c0;

  pwm_meter #(.CNT_W(CNT_W), .GLITCH(2), .TIMEOUT(1000)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pwm_data (pwm),
    .i_en       (en),
    .o_period   (o_period),
    .o_high     (o_high),
    .o_valid    (o_valid),
    .o_timeout  (o_timeout),
    .o_locked   (o_locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int period, input int high);
    exp_t e;
    e.period = CNT_W'(period);
    e.high   = CNT_W'(high);
    exp_q.push_back(e);
  endtask

  // Monitor: decoupled from stimulus, compares every strobe against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid || o_timeout)
        check("valid_timeout_exclusive", longint'(o_valid & o_timeout), 0);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("period", o_period, e.period);
          check("high", o_high, e.high);
        end
      end
      if (o_timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      pwm = 1'b1;
      repeat (hi) @(negedge clk);
      pwm = 1'b0;
      for (int i = 0; i < lo; i++) begin
        if (i == lo / 2) check("locked_in_low", o_locked, 1);
        @(negedge clk);
      end
    end
  endtask

  // 10 high / 30 low with a 1-cycle dip in the high phase and a 1-cycle spike
  // in the low phase; the filter must swallow both.
  task automatic glitch_wave(input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 40; i++) begin
        pwm = (i < 10) ? (i != 4) : (i == 20);
        if (i == 25) check("locked_glitch", o_locked, 1);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", o_period, 0);
    check("rst_high", o_high, 0);
    check("rst_valid", o_valid, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_locked", o_locked, 0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_unlocked", o_locked, 0);

    // Clean 10/30 wave: first rise arms, each later rise reports 40/10.
    repeat (5) push(40, 10);
    wave(10, 30, 6);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("en_low_unlocked", o_locked, 0);
    repeat (2) @(negedge clk);
    en = 1'b1;

    // Glitchy wave: identical results, no extra strobes.
    repeat (5) push(40, 10);
    glitch_wave(6);

    // Held high after arming: rise closes the last 40/10 period, then timeout.
    push(40, 10);
    c0  = cyc;
    pwm = 1'b1;
    repeat (1200) @(negedge clk);
    check("timeout_once", to_cnt, 1);
    check("timeout_latency_ok", longint'((to_cyc - c0) >= 1005 && (to_cyc - c0) <= 1007), 1);
    check("timeout_unlocked", o_locked, 0);
    check("timeout_hold_period", o_period, 40);
    check("timeout_hold_high", o_high, 10);
    pwm = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset pulse mid MEAS_LOW discards the partial count.
    repeat (3) push(40, 10);
    wave(10, 30, 3);
    pwm = 1'b1;
    repeat (10) @(negedge clk);
    pwm = 1'b0;
    repeat (25) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_period", o_period, 0);
    check("async_rst_high", o_high, 0);
    check("async_rst_valid", o_valid, 0);
    check("async_rst_timeout", o_timeout, 0);
    check("async_rst_locked", o_locked, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    repeat (2) push(40, 10);
    wave(10, 30, 3);

    // Enable dropped for 5 cycles mid MEAS_HIGH, then re-arm.
    push(40, 10);
    for (int i = 0; i < 40; i++) begin
      pwm = (i < 10);
      en  = !(i >= 8 && i < 13);
      if (i == 11) check("en_gap_unlocked", o_locked, 0);
      @(negedge clk);
    end
    en = 1'b1;
    repeat (2) push(40, 10);
    wave(10, 30, 3);

    // Period 1000 / high 500: rise lands exactly on cnt == TIMEOUT.
    push(40, 10);
    push(1000, 500);
    wave(500, 500, 1);
    pwm = 1'b1;
    repeat (500) @(negedge clk);
    pwm = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    check("final_unlocked", o_locked, 0);
    check("queue_drained", exp_q.size(), 0);
    check("timeout_total", to_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
